shumezuesi_sek16b: RTL

- Sequential 16x16 unsigned shift-add multiplier for the 16-bit CPU datapath.
- Sits directly upstream and downstream of the shared 16-bit ripple adder:
  - drives the adder operands each cycle;
  - consumes the adder's sum and carry-out to build a 32-bit product over 16 iterations.
- Start/Busy/Done handshake to the control unit.

---
 rtl/shumezuesi_sek16b_if.sv | 26 ++
 rtl/shumezuesi_sek16b.sv | 97 +++++++++
 2 files changed

// File: rtl/shumezuesi_sek16b_if.sv
// Multiplier bus: control handshake, operands, result and
// the operand/result wires of the shared 16-bit adder.
interface shumezuesi_sek16b_if #(
    parameter int WIDTH = 16
);
    logic               Start;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [WIDTH-1:0]   AddA;
    logic [WIDTH-1:0]   AddB;
    logic [WIDTH-1:0]   AddSum;
    logic               AddCarry;
    logic [2*WIDTH-1:0] Product;
    logic               Busy;
    logic               Done;

    modport master (
        output Start, A, B, AddSum, AddCarry,
        input  AddA, AddB, Product, Busy, Done
    );

    modport slave (
        input  Start, A, B, AddSum, AddCarry,
        output AddA, AddB, Product, Busy, Done
    );
endinterface

// File: rtl/shumezuesi_sek16b.sv
// Sequential 16x16 unsigned shift-add multiplier using the shared adder.
// Optional EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module shumezuesi_sek16b #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input logic               Clock,
    input logic               ResetN,
    shumezuesi_sek16b_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   ph;
    logic [WIDTH-1:0]   pl;
    logic [WIDTH-1:0]   mc;
    logic [CNT_W-1:0]   cnt;
    logic               busy;
    logic               done;

    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] step_fin;
    logic               last;
    logic               finish;

    // One iteration: (carry:sum:PL) shifted right by one.
    assign step = {bus.AddCarry, bus.AddSum, pl[WIDTH-1:1]};
    assign last = (cnt == CNT_W'(WIDTH - 1));

`ifdef EARLY_TERM_EN
    logic [WIDTH-1:0]   rem_mask;
    logic               rem_zero;
    logic [CNT_W-1:0]   rem_cnt;

    // Unconsumed multiplier bits sit at the bottom of PL after the shift.
    assign rem_mask = {WIDTH{1'b1}} >> (cnt + CNT_W'(1));
    assign rem_zero = ~|(step[WIDTH-1:0] & rem_mask);
    assign rem_cnt  = CNT_W'(WIDTH - 1) - cnt;
    assign step_fin = step >> rem_cnt;
    assign finish   = last | rem_zero;
`else
    assign step_fin = step;
    assign finish   = last;
`endif

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state <= IDLE;
            ph    <= '0;
            pl    <= '0;
            mc    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (bus.Start) begin
                        mc    <= bus.A;
                        ph    <= '0;
                        pl    <= bus.B;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    {ph, pl} <= step_fin;
                    cnt      <= cnt + CNT_W'(1);
                    if (finish) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.AddA    = ph;
    assign bus.AddB    = pl[0] ? mc : '0;
    assign bus.Product = {ph, pl};
    assign bus.Busy    = busy;
    assign bus.Done    = done;
endmodule
